// File: rtl/conv_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sum_accumulator
//  Description : Final reduction stage after the L3 adder array. Sums all
//                lanes of each input beat, accumulates NUM_PASSES beats into
//                one unsigned convolution result with saturation, and holds
//                that result on a valid/ready output register.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_sum_accumulator #(
  parameter int DATA_WIDTH = 18,
  parameter int ARRAY_SIZE = 2,
  parameter int NUM_PASSES = 4,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [ARRAY_SIZE*(DATA_WIDTH+1)-1:0]   in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ACC_WIDTH-1:0]                   out_data,
  output logic                                   out_sat
);

  localparam int LANE_W = DATA_WIDTH + 1;
  localparam int CNT_W  = $clog2(NUM_PASSES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [ACC_WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0]     pass_cnt_q,  pass_cnt_d;
  logic                 sat_q,       sat_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q,  out_data_d;
  logic                 out_sat_q,   out_sat_d;

  logic [ACC_WIDTH-1:0] beat_sum;
  logic [ACC_WIDTH-1:0] acc_base;
  logic                 sat_base;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [CNT_W-1:0]     cnt_next;
  logic                 accept;
  logic                 xfer;

  // No new beat may enter while a finished result is still waiting.
  assign in_ready  = enable & (state_q != ST_DONE);
  assign accept    = in_valid & in_ready;
  assign xfer      = enable & out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Zero-extend every lane to accumulator width and add them together.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      beat_sum = beat_sum + ACC_WIDTH'(in_data[i*LANE_W +: LANE_W]);
    end
  end

  // Next-state, accumulate/saturate and output-register update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pass_cnt_d  = pass_cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    // The first beat of a set starts from zero regardless of leftover state.
    acc_base = (state_q == ST_ACCUM) ? acc_q : '0;
    sat_base = (state_q == ST_ACCUM) ? sat_q : 1'b0;
    sum_ext  = {1'b0, acc_base} + {1'b0, beat_sum};
    cnt_next = (state_q == ST_ACCUM) ? (pass_cnt_q + CNT_W'(1)) : CNT_W'(1);

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          pass_cnt_d = cnt_next;
          // Carry out of the extended sum means the result no longer fits.
          acc_d      = sum_ext[ACC_WIDTH] ? '1 : sum_ext[ACC_WIDTH-1:0];
          sat_d      = sat_base | sum_ext[ACC_WIDTH];
          if (cnt_next == CNT_W'(NUM_PASSES)) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            out_data_d  = acc_d;
            out_sat_d   = sat_d;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_DONE: begin
        if (xfer) begin
          state_d     = ST_IDLE;
          acc_d       = '0;
          pass_cnt_d  = '0;
          sat_d       = 1'b0;
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      pass_cnt_q  <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pass_cnt_q  <= pass_cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_sum_accumulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_conv_sum_accumulator
//  Description : Self-checking bench for conv_sum_accumulator. Three
//                instances: default (AW=24, NP=4), narrow (AW=21, NP=4) and
//                single-pass (NP=1). Only the selected instance is enabled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_sum_accumulator;

  localparam int DW = 18;
  localparam int AS = 2;
  localparam int LW = DW + 1;

  logic              clk;
  logic              reset;
  logic              en_on;
  int                cur;
  logic              en_main, en_aw, en_np1;
  logic              in_valid;
  logic [AS*LW-1:0]  in_data;
  logic              out_ready;

  logic              rdy_main, ov_main, os_main;
  logic [23:0]       od_main;
  logic              rdy_aw, ov_aw, os_aw;
  logic [20:0]       od_aw;
  logic              rdy_np1, ov_np1, os_np1;
  logic [23:0]       od_np1;

  logic              s_rdy, s_ov, s_os;
  logic [23:0]       s_od;

  int tests_run;
  int tests_failed;

  conv_sum_accumulator #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .NUM_PASSES(4), .ACC_WIDTH(24)) u_dut (
    .clk(clk), .reset(reset), .enable(en_main), .in_valid(in_valid), .in_ready(rdy_main),
    .in_data(in_data), .out_valid(ov_main), .out_ready(out_ready), .out_data(od_main), .out_sat(os_main));

  conv_sum_accumulator #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .NUM_PASSES(4), .ACC_WIDTH(21)) u_dut_aw21 (
    .clk(clk), .reset(reset), .enable(en_aw), .in_valid(in_valid), .in_ready(rdy_aw),
    .in_data(in_data), .out_valid(ov_aw), .out_ready(out_ready), .out_data(od_aw), .out_sat(os_aw));

  conv_sum_accumulator #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .NUM_PASSES(1), .ACC_WIDTH(24)) u_dut_np1 (
    .clk(clk), .reset(reset), .enable(en_np1), .in_valid(in_valid), .in_ready(rdy_np1),
    .in_data(in_data), .out_valid(ov_np1), .out_ready(out_ready), .out_data(od_np1), .out_sat(os_np1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable only the instance under test; the others stay frozen.
  always_comb begin
    en_main = en_on & (cur == 0);
    en_aw   = en_on & (cur == 1);
    en_np1  = en_on & (cur == 2);
  end

  // Route the selected instance's outputs to common check signals.
  always_comb begin
    s_rdy = rdy_main; s_ov = ov_main; s_os = os_main; s_od = od_main;
    if (cur == 1) begin
      s_rdy = rdy_aw;  s_ov = ov_aw;  s_os = os_aw;  s_od = {3'b000, od_aw};
    end else if (cur == 2) begin
      s_rdy = rdy_np1; s_ov = ov_np1; s_os = os_np1; s_od = od_np1;
    end
  end

  typedef struct {
    int               sel;
    logic [3:0][18:0] l0;
    logic [3:0][18:0] l1;
    logic [23:0]      exp_data;
    logic             exp_sat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int idx, input int sel,
                         input int a0, input int b0, input int a1, input int b1,
                         input int a2, input int b2, input int a3, input int b3,
                         input int exp_d, input logic exp_s);
    vecs[idx].sel      = sel;
    vecs[idx].l0[0] = 19'(a0); vecs[idx].l1[0] = 19'(b0);
    vecs[idx].l0[1] = 19'(a1); vecs[idx].l1[1] = 19'(b1);
    vecs[idx].l0[2] = 19'(a2); vecs[idx].l1[2] = 19'(b2);
    vecs[idx].l0[3] = 19'(a3); vecs[idx].l1[3] = 19'(b3);
    vecs[idx].exp_data = 24'(exp_d);
    vecs[idx].exp_sat  = exp_s;
  endtask

  // Present one beat; it is accepted at the following rising edge.
  task automatic send_beat(input int a, input int b);
    @(negedge clk);
    en_on    = 1'b1;
    in_valid = 1'b1;
    in_data  = {19'(b), 19'(a)};
    #1;
    check("in_ready_during_set", 32'(s_rdy), 32'd1);
    check("out_valid_during_set", 32'(s_ov), 32'd0);
  endtask

  // Result must appear right after the last accept; out_ready=1 transfers it.
  task automatic finish_set(input logic [23:0] exp_d, input logic exp_s);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("out_valid_after_last", 32'(s_ov), 32'd1);
    check("out_data", 32'(s_od), 32'(exp_d));
    check("out_sat", 32'(s_os), 32'(exp_s));
    check("in_ready_in_done", 32'(s_rdy), 32'd0);
    @(negedge clk);
    #1;
    check("out_valid_after_xfer", 32'(s_ov), 32'd0);
    check("out_data_after_xfer", 32'(s_od), 32'd0);
    check("out_sat_after_xfer", 32'(s_os), 32'd0);
    check("in_ready_after_xfer", 32'(s_rdy), 32'd1);
  endtask

  task automatic run_vec(input int i);
    cur       = vecs[i].sel;
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) send_beat(int'(vecs[i].l0[b]), int'(vecs[i].l1[b]));
    finish_set(vecs[i].exp_data, vecs[i].exp_sat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cur          = 0;
    en_on        = 1'b1;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;

    set_vec(0, 0,      1,      2,      3,      4,      5,      6,      7,      8,      36, 1'b0);
    set_vec(1, 0, 524287, 524287, 524287, 524287, 524287, 524287, 524287, 524287, 4194296, 1'b0);
    set_vec(2, 1, 524287, 524287, 524287, 524287, 524287, 524287, 524287, 524287, 2097151, 1'b1);
    set_vec(3, 0,     10,     10,     10,     10,     10,     10,     10,     10,      80, 1'b0);
    set_vec(4, 0,      0,      0,      0,      0,      0,      0,      0,      0,       0, 1'b0);
    set_vec(5, 0, 524287,      0,      0, 524287,      1,      1,    100,     50, 1048726, 1'b0);

    // Reset state of every instance.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(ov_main), 32'd0);
    check("rst_out_data", 32'(od_main), 32'd0);
    check("rst_out_sat", 32'(os_main), 32'd0);
    check("rst_in_ready", 32'(rdy_main), 32'd1);
    check("rst_aw21_out_valid", 32'(ov_aw), 32'd0);
    check("rst_np1_out_valid", 32'(ov_np1), 32'd0);

    // Table-driven sets.
    for (int i = 0; i < 6; i++) run_vec(i);

    // Held result: out_ready low with a waiting upstream beat.
    cur = 0; out_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(2, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {19'd9, 19'd9};
      #1;
      check("hold_in_ready", 32'(s_rdy), 32'd0);
      check("hold_out_valid", 32'(s_ov), 32'd1);
      check("hold_out_data", 32'(s_od), 32'd20);
    end
    // Enable low in DONE: out_ready is ignored and the result stays put.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      en_on = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("frozen_done_out_valid", 32'(s_ov), 32'd1);
      check("frozen_done_in_ready", 32'(s_rdy), 32'd0);
    end
    @(negedge clk);
    en_on = 1'b1;
    #1;
    check("release_out_valid", 32'(s_ov), 32'd1);
    @(negedge clk);
    #1;
    check("released_out_valid", 32'(s_ov), 32'd0);
    check("released_in_ready", 32'(s_rdy), 32'd1);
    run_vec(0);

    // Enable dropped for 3 cycles after the 2nd beat.
    cur = 0; out_ready = 1'b1;
    send_beat(1, 2);
    send_beat(3, 4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      en_on = 1'b0; in_valid = 1'b1; in_data = {19'd6, 19'd5};
      #1;
      check("stall_in_ready", 32'(s_rdy), 32'd0);
      check("stall_out_valid", 32'(s_ov), 32'd0);
    end
    send_beat(5, 6);
    send_beat(7, 8);
    finish_set(24'd36, 1'b0);

    // Reset mid-set discards the partial sum.
    send_beat(1, 2);
    send_beat(3, 4);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    #1;
    check("midset_rst_out_valid", 32'(s_ov), 32'd0);
    check("midset_rst_in_ready", 32'(s_rdy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_vec(3);

    // Reset while a result is pending discards it immediately.
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pending_out_valid", 32'(s_ov), 32'd1);
    check("pending_out_data", 32'(s_od), 32'd8);
    reset = 1'b1;
    #1;
    check("done_rst_out_valid", 32'(s_ov), 32'd0);
    check("done_rst_out_data", 32'(s_od), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single-pass instance: one beat per result.
    cur = 2; out_ready = 1'b1;
    send_beat(100, 200);
    finish_set(24'd300, 1'b0);
    send_beat(7, 5);
    finish_set(24'd12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
